// File: rtl/decode_unit_pkg.sv
// rtl/decode_unit_pkg.sv - opcode/format types and encoding constants for decode_unit
package instr_type;

  // op_invalid sits at zero so a cleared entry reads back as invalid
  typedef enum logic [3:0] {
    op_invalid        = 4'd0,
    op_lui            = 4'd1,
    op_auipc          = 4'd2,
    op_jal            = 4'd3,
    op_jalr           = 4'd4,
    op_branch_type    = 4'd5,
    op_load_type      = 4'd6,
    op_store_type     = 4'd7,
    op_imm_arith      = 4'd8,
    op_reg_arith_type = 4'd9,
    op_fence          = 4'd10,
    op_system         = 4'd11
  } opcode_t;

  typedef enum logic [2:0] {
    fmt_i    = 3'd0,
    fmt_s    = 3'd1,
    fmt_b    = 3'd2,
    fmt_u    = 3'd3,
    fmt_j    = 3'd4,
    fmt_none = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_REG_ARITH = 7'b0110011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/decode_unit_imm_gen.sv
// rtl/decode_unit_imm_gen.sv - combinational immediate extraction and sign extension
module imm_gen
  import instr_type::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  // assemble the 32-bit immediate for the format, then sign-extend from bit 31
  always_comb begin
    raw = '0;
    case (fmt)
      fmt_i:   raw = {{20{instr[31]}}, instr[31:20]};
      fmt_s:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      fmt_b:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      fmt_u:   raw = {instr[31:12], 12'b0};
      fmt_j:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - instruction decoder with 2-entry in-order skid buffer
module decode_unit
  import instr_type::*;
#(
  parameter int XLEN     = 32,
  parameter int EN_M     = 0,
  parameter int EN_ZICSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output opcode_t         out_opcode,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_is_mext,
  output logic            out_illegal
);

  typedef struct packed {
    opcode_t         opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            is_mext;
    logic            illegal;
  } entry_t;

  entry_t     buf_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;

  opcode_t         dec_opcode;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal, dec_mext;
  logic [XLEN-1:0] dec_imm;
  logic [6:0]      funct7;
  logic            accept, drain;

  assign funct7 = in_instr[31:25];

  // classify the opcode, pick the immediate format and flag illegal encodings
  always_comb begin
    dec_opcode  = op_invalid;
    dec_fmt     = fmt_none;
    dec_illegal = 1'b0;
    dec_mext    = 1'b0;
    case (in_instr[6:0])
      OPC_LUI:       begin dec_opcode = op_lui;         dec_fmt = fmt_u; end
      OPC_AUIPC:     begin dec_opcode = op_auipc;       dec_fmt = fmt_u; end
      OPC_JAL:       begin dec_opcode = op_jal;         dec_fmt = fmt_j; end
      OPC_JALR:      begin dec_opcode = op_jalr;        dec_fmt = fmt_i; end
      OPC_BRANCH:    begin dec_opcode = op_branch_type; dec_fmt = fmt_b; end
      OPC_LOAD:      begin dec_opcode = op_load_type;   dec_fmt = fmt_i; end
      OPC_STORE:     begin dec_opcode = op_store_type;  dec_fmt = fmt_s; end
      OPC_IMM_ARITH: begin dec_opcode = op_imm_arith;   dec_fmt = fmt_i; end
      OPC_FENCE:     begin dec_opcode = op_fence;       dec_fmt = fmt_i; end
      OPC_REG_ARITH: begin
        dec_opcode = op_reg_arith_type;
        if (funct7 == F7_MEXT && EN_M != 0) dec_mext = 1'b1;
        else if (funct7 != F7_BASE && funct7 != F7_ALT) dec_illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_opcode = op_system;
        dec_fmt    = fmt_i;
        if (in_instr[14:12] != 3'b000 && EN_ZICSR == 0) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // an illegal entry carries no opcode meaning and no immediate
    if (dec_illegal) begin
      dec_opcode = op_invalid;
      dec_fmt    = fmt_none;
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // occupancy after this cycle's accept/drain pair
  always_comb begin
    count_d = count_q;
    case ({accept, drain})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // buffer storage and pointers; flush wins over any same-cycle transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        buf_q[wr_ptr_q] <= '{opcode:  dec_opcode,
                             funct3:  in_instr[14:12],
                             rd:      in_instr[11:7],
                             rs1:     in_instr[19:15],
                             rs2:     in_instr[24:20],
                             imm:     dec_imm,
                             pc:      in_pc,
                             is_mext: dec_mext,
                             illegal: dec_illegal};
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (drain) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign out_opcode  = buf_q[rd_ptr_q].opcode;
  assign out_funct3  = buf_q[rd_ptr_q].funct3;
  assign out_rd      = buf_q[rd_ptr_q].rd;
  assign out_rs1     = buf_q[rd_ptr_q].rs1;
  assign out_rs2     = buf_q[rd_ptr_q].rs2;
  assign out_imm     = buf_q[rd_ptr_q].imm;
  assign out_pc      = buf_q[rd_ptr_q].pc;
  assign out_is_mext = buf_q[rd_ptr_q].is_mext;
  assign out_illegal = buf_q[rd_ptr_q].illegal;

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the width of the pc and immediate datapath; legal values are 32 and 64.
REQ-002 The block SHALL have parameter EN_M, default 0; when 1, M-extension R-type encodings are legal.
REQ-003 The block SHALL have parameter EN_ZICSR, default 1; when 1, CSR encodings (SYSTEM, funct3!=0) are legal.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  producer presents an instruction.
REQ-008 in_ready  output  1  block can accept an instruction this cycle.
REQ-009 in_instr  input  32  raw instruction word.
REQ-010 in_pc  input  XLEN  pc of in_instr.
REQ-011 out_valid  output  1  decoded entry available.
REQ-012 out_ready  input  1  consumer accepts the entry.
REQ-013 out_opcode  output  opcode_t  opcode kind.
REQ-014 out_funct3  output  3  instr[14:12].
REQ-015 out_rd, out_rs1, out_rs2  output  5 each  instr[11:7], [19:15], [24:20], raw for every format.
REQ-016 out_imm  output  XLEN  sign-extended immediate.
REQ-017 out_pc  output  XLEN  pc carried with the entry.
REQ-018 out_is_mext  output  1  entry is a legal M-extension op.
REQ-019 out_illegal  output  1  entry is an illegal encoding.

Function
REQ-020 Decode SHALL be combinational on the input word; decoded fields SHALL be stored in a 2-entry in-order skid buffer, with the head driving the out_* ports.
REQ-021 Transfer: accept on in_valid&&in_ready; drain on out_valid&&out_ready.
REQ-022 in_ready SHALL equal (count!=2) && !rst; out_valid SHALL equal (count!=0).
REQ-023 Latency: an entry accepted at edge N into an empty buffer SHALL have out_valid high after edge N, i.e. 1 cycle.
REQ-024 Accept and drain in the same cycle SHALL leave count unchanged and preserve order.
REQ-025 While out_valid && !out_ready, all out_* ports SHALL hold stable.
REQ-026 Opcode map (instr[6:0]): 0110111 lui, 0010111 auipc, 1101111 jal, 1100111 jalr, 1100011 branch, 0000011 load, 0100011 store, 0010011 imm_arith, 0110011 reg_arith, 0001111 fence, 1110011 system; anything else op_invalid.
REQ-027 illegal SHALL be set, with out_opcode forced to op_invalid, for:
  - an unknown opcode;
  - reg_arith with funct7 not in {0000000, 0100000}, or 0000001 when EN_M=1;
  - SYSTEM with funct3!=0 when EN_ZICSR=0.
REQ-028 out_is_mext SHALL be 1 only for reg_arith with funct7=0000001 and EN_M=1.
REQ-029 Immediate by format, sign-extended from the instr[31] MSB to XLEN:
  - I: jalr, load, imm_arith, fence, system;
  - S: store;
  - B: branch;
  - U: lui, auipc, with low 12 bits zero;
  - J: jal;
  - 0: reg_arith and invalid.
REQ-030 flush SHALL set count to 0 at the next edge, discard any same-cycle accept, and override a same-cycle drain.

Reset
REQ-031 While rst is high, the block SHALL hold count=0, out_valid=0, in_ready=0, all out_* data ports 0, and out_opcode=op_invalid.
REQ-032 Reset asserted mid-operation SHALL discard buffered entries immediately; after deassertion, in_ready SHALL be 1 and there SHALL be no spurious out_valid.

Structure
REQ-033 Package instr_type SHALL hold opcode_t, a new imm_fmt_t (I, S, B, U, J, NONE), and the opcode and funct7 constants.
REQ-034 Sub-module imm_gen SHALL be combinational and map (instr, imm_fmt_t) to the XLEN immediate; the buffer and control SHALL stay in decode_unit.

Verification
REQ-035 Send 0xFFF00093 into an empty buffer with out_ready=1 -> next cycle op_imm_arith, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
REQ-036 Send 0xFE208EE3 -> op_branch_type, rs1=1, rs2=2, imm=-4; with XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
REQ-037 Send 0x022081B3 with EN_M=0 -> op_invalid, illegal=1; with EN_M=1 -> op_reg_arith_type, out_is_mext=1, rd=3.
REQ-038 Hold out_ready=0 and offer 3 instructions on consecutive cycles -> in_ready drops after 2 accepts, third held off; releasing out_ready drains in order A, B, then C.
REQ-039 With count=2 and in_valid=1, pulse flush -> next cycle out_valid=0 and in_ready=1, and the input offered that cycle is not emitted.
REQ-040 Assert rst asynchronously with count=1 mid-cycle -> out_valid falls without waiting for an edge, outputs are zero, and opcode is op_invalid.
